// File: rtl/carry_select_adder_pkg.sv
// carry_select_adder_pkg: default geometry shared by the adder and its ripple blocks
package carry_select_adder_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BLOCK = 4;
endpackage

// File: rtl/carry_select_adder_rca_block.sv
// rca_block: combinational ripple-carry adder slice
module rca_block
  import carry_select_adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);
  logic [BLOCK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < BLOCK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[BLOCK];
endmodule

// File: rtl/carry_select_adder.sv
// carry_select_adder: registered unsigned {Cout,Sum} = A + B + Cin built from carry-select blocks
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int NB = WIDTH / BLOCK;
  if (WIDTH % BLOCK != 0) begin : g_chk
    $fatal(1, "carry_select_adder: WIDTH must be a multiple of BLOCK");
  end
  logic [NB:0]      sel;
  logic [WIDTH-1:0] sum_c;
  assign sel[0] = Cin;
  for (genvar k = 0; k < NB; k++) begin : g_blk
    if (k == 0) begin : g_base
      rca_block #(.BLOCK(BLOCK)) u_rca (
        .a(A[BLOCK-1:0]), .b(B[BLOCK-1:0]), .cin(sel[0]),
        .sum(sum_c[BLOCK-1:0]), .cout(sel[1])
      );
    end else begin : g_sel
      // both carry hypotheses resolve in parallel; the incoming carry only drives the muxes
      logic [BLOCK-1:0] s0, s1;
      logic             c0, c1;
      rca_block #(.BLOCK(BLOCK)) u_rca0 (
        .a(A[k*BLOCK +: BLOCK]), .b(B[k*BLOCK +: BLOCK]), .cin(1'b0),
        .sum(s0), .cout(c0)
      );
      rca_block #(.BLOCK(BLOCK)) u_rca1 (
        .a(A[k*BLOCK +: BLOCK]), .b(B[k*BLOCK +: BLOCK]), .cin(1'b1),
        .sum(s1), .cout(c1)
      );
      assign sum_c[k*BLOCK +: BLOCK] = sel[k] ? s1 : s0;
      assign sel[k+1]                = sel[k] ? c1 : c0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) {Cout, Sum} <= '0;
    else     {Cout, Sum} <= {sel[NB], sum_c};
  end
endmodule

// File: tb/tb_carry_select_adder.sv
// tb_carry_select_adder: directed and random scoreboard check of the registered carry-select adder
module tb_carry_select_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, sum;
  logic         cin, cout;
  logic [W:0]   q[$];
  int           checks = 0;
  int           passes = 0;

  carry_select_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    rst = r; a = x; b = y; cin = c;
    q.push_back(r ? '0 : ({1'b0, x} + {1'b0, y} + {{W{1'b0}}, c}));
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    assert ({cout, sum} === e) passes++;
    else $error("FAIL %s got={%b,%h} exp={%b,%h}", tag, cout, sum, e[W], e[W-1:0]);
  endtask

  initial begin
    step("reset_0", 1'b1, 8'hFF, 8'hFF, 1'b1);
    step("reset_1", 1'b1, 8'hFF, 8'hFF, 1'b1);
    step("post_reset", 1'b0, 8'hFF, 8'hFF, 1'b1);
    step("ff_plus_01", 1'b0, 8'hFF, 8'h01, 1'b0);
    step("ff_ff_c0", 1'b0, 8'hFF, 8'hFF, 1'b0);
    step("ff_ff_c1", 1'b0, 8'hFF, 8'hFF, 1'b1);
    step("blk0_carry", 1'b0, 8'h05, 8'h03, 1'b0);
    step("upper_gen", 1'b0, 8'hF0, 8'hB0, 1'b1);
    step("zero", 1'b0, 8'h00, 8'h00, 1'b0);
    step("ff_plus_cin", 1'b0, 8'hFF, 8'h00, 1'b1);
    step("blk_boundary", 1'b0, 8'h0F, 8'h01, 1'b0);
    step("sel_no_carry", 1'b0, 8'h70, 8'h0F, 1'b0);
    for (int i = 0; i < 10000; i++)
      step("random", 1'b0, W'($urandom), W'($urandom), 1'($urandom));
    step("midstream_rst", 1'b1, 8'hA5, 8'h5A, 1'b1);
    step("after_rst", 1'b0, 8'h80, 8'h80, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
